// File: rtl/eeprom_controller.sv
// Word-addressed EEPROM store: combinational bus read, bus write strobe,
// streamed program bursts, full-array erase, write protect and status pulses.
module eeprom_controller #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  ram_in,
    input  logic                  ram_out,
    output logic [DATA_WIDTH-1:0] Qram,
    output logic [DATA_WIDTH-1:0] Qramout,
    input  logic                  wp,
    input  logic                  prog_start,
    input  logic [ADDR_WIDTH-1:0] prog_base,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  prog_valid,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_ready,
    input  logic                  erase_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned END_W = ADDR_WIDTH + 2;

    localparam logic [ADDR_WIDTH:0]   DEPTH_A = LEN_W'(DEPTH);
    localparam logic [END_W-1:0]      DEPTH_E = END_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        ERASE = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH:0]     remaining;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    addr_ok;
    logic [END_W-1:0]        prog_end;
    logic                    prog_legal;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;

    assign addr_ok    = ({1'b0, address} < DEPTH_A);
    assign prog_end   = END_W'(prog_base) + END_W'(prog_len);
    assign prog_legal = (prog_len != '0) && (prog_end <= DEPTH_E);

    // Bus-side read path; out-of-range addresses read as zero.
    assign Qram       = addr_ok ? mem[IDX_W'(address)] : '0;
    assign busy       = (state != IDLE);
    assign prog_ready = (state == PROG);
    assign Qramout    = (ram_out && state == IDLE) ? Qram : '0;

    // Single write port shared by bus writes, burst words and erase sweep.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        case (state)
            IDLE: begin
                if (ram_in && !wp && addr_ok) begin
                    mem_we = 1'b1;
                    mem_wa = address;
                    mem_wd = data;
                end
            end
            PROG: begin
                if (prog_valid) begin
                    mem_we = 1'b1;
                    mem_wa = ptr;
                    mem_wd = prog_data;
                end
            end
            ERASE: begin
                mem_we = 1'b1;
                mem_wa = ptr;
                mem_wd = '1;
            end
            default: ;
        endcase
    end

    // Array contents survive reset; a reset edge only suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[IDX_W'(mem_wa)] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Erase has priority over a simultaneous program request.
                    if (erase_start) begin
                        if (wp) begin
                            err <= 1'b1;
                        end else begin
                            state <= ERASE;
                            ptr   <= '0;
                        end
                    end else if (prog_start) begin
                        if (wp || !prog_legal) begin
                            err <= 1'b1;
                        end else begin
                            state     <= PROG;
                            ptr       <= prog_base;
                            remaining <= prog_len;
                        end
                    end
                end
                PROG: begin
                    if (prog_valid) begin
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ERASE: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_controller.sv
// Directed bench for eeprom_controller with a small array so the erase
// sweep and out-of-range addresses are cheap to reach.
module tb_eeprom_controller;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 6;
    localparam int unsigned DP = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data;
    logic [AW-1:0] address;
    logic          ram_in;
    logic          ram_out;
    logic [DW-1:0] Qram;
    logic [DW-1:0] Qramout;
    logic          wp;
    logic          prog_start;
    logic [AW-1:0] prog_base;
    logic [AW:0]   prog_len;
    logic          prog_valid;
    logic [DW-1:0] prog_data;
    logic          prog_ready;
    logic          erase_start;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    eeprom_controller #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .address    (address),
        .ram_in     (ram_in),
        .ram_out    (ram_out),
        .Qram       (Qram),
        .Qramout    (Qramout),
        .wp         (wp),
        .prog_start (prog_start),
        .prog_base  (prog_base),
        .prog_len   (prog_len),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .erase_start(erase_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a;
        data    = d;
        ram_in  = 1'b1;
        step();
        ram_in  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        address = a;
        #1;
        check(tag, 32'(Qram), 32'(exp));
    endtask

    // Counts busy cycles until idle, bounded so a stuck FSM still ends the run.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    int n;
    int bad;
    logic [DW-1:0] word;
    logic [1:0] pat_valid [6];
    logic [DW-1:0] pat_data [6];

    initial begin
        reset = 1'b1; data = '0; address = '0; ram_in = 1'b0; ram_out = 1'b0;
        wp = 1'b0; prog_start = 1'b0; prog_base = '0; prog_len = '0;
        prog_valid = 1'b0; prog_data = '0; erase_start = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(prog_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Bus write, gated output, out-of-range write
        bus_write(6'd3, 8'hA5);
        read_check("bus_rd3", 6'd3, 8'hA5);
        ram_out = 1'b1; #1;
        check("qramout_on", 32'(Qramout), 32'hA5);
        ram_out = 1'b0; #1;
        check("qramout_off", 32'(Qramout), 32'h0);
        bus_write(6'(DP + 1), 8'h5A);
        read_check("oob_rd", 6'(DP + 1), 8'h00);

        bus_write(6'd5, 8'h11);
        wp = 1'b1;
        bus_write(6'd5, 8'h22);
        wp = 1'b0;
        read_check("wp_write_drop", 6'd5, 8'h11);

        // Program burst with a two-cycle valid gap
        prog_base = 6'd10; prog_len = 7'd4; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        check("prog_ready", 32'(prog_ready), 32'd1);
        pat_valid = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        pat_data  = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd3, 8'd4};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) n++;
            prog_valid = pat_valid[i][0];
            prog_data  = pat_data[i];
            step();
        end
        prog_valid = 1'b0;
        check("prog_busy_cycles", 32'(n), 32'd6);
        check("prog_done", 32'(done), 32'd1);
        check("prog_idle", 32'(busy), 32'd0);
        step();
        check("prog_done_clr", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) read_check("prog_word", 6'(10 + i), 8'(i + 1));

        // Erase with bus writes attempted throughout
        erase_start = 1'b1;
        step();
        erase_start = 1'b0;
        ram_out = 1'b1;
        #1;
        check("erase_qramout0", 32'(Qramout), 32'h0);
        address = 6'd3; data = 8'h00; ram_in = 1'b1;
        wait_idle(n);
        ram_in = 1'b0; ram_out = 1'b0;
        check("erase_busy_cycles", 32'(n), 32'(DP));
        check("erase_done", 32'(done), 32'd1);
        bad = 0;
        for (int i = 0; i < DP; i++) begin
            address = 6'(i);
            #1;
            if (Qram !== 8'hFF) bad++;
        end
        check("erase_all_ones", 32'(bad), 32'd0);
        read_check("erase_bus_drop", 6'd3, 8'hFF);

        // Rejections
        bus_write(6'd0, 8'h33);
        wp = 1'b1; erase_start = 1'b1;
        step();
        wp = 1'b0; erase_start = 1'b0;
        check("rej_wp_err", 32'(err), 32'd1);
        check("rej_wp_idle", 32'(busy), 32'd0);
        step();
        check("rej_err_clr", 32'(err), 32'd0);
        read_check("rej_wp_mem", 6'd0, 8'h33);

        prog_base = 6'(DP - 2); prog_len = 7'd3; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        check("rej_range_err", 32'(err), 32'd1);
        check("rej_range_idle", 32'(busy), 32'd0);
        read_check("rej_range_mem", 6'(DP - 2), 8'hFF);

        prog_base = 6'd4; prog_len = 7'd0; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        check("rej_len0_err", 32'(err), 32'd1);
        check("rej_len0_idle", 32'(busy), 32'd0);

        // Burst ending exactly at the last word is legal
        prog_base = 6'(DP - 2); prog_len = 7'd2; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        check("edge_no_err", 32'(err), 32'd0);
        prog_valid = 1'b1; prog_data = 8'h55;
        step();
        prog_data = 8'h66;
        step();
        prog_valid = 1'b0;
        check("edge_done", 32'(done), 32'd1);
        read_check("edge_w0", 6'(DP - 2), 8'h55);
        read_check("edge_w1", 6'(DP - 1), 8'h66);

        // Simultaneous starts: erase wins, no err
        prog_base = 6'd0; prog_len = 7'd2; prog_start = 1'b1; erase_start = 1'b1;
        step();
        prog_start = 1'b0; erase_start = 1'b0;
        check("both_err", 32'(err), 32'd0);
        check("both_busy", 32'(busy), 32'd1);
        check("both_not_prog", 32'(prog_ready), 32'd0);
        wait_idle(n);
        check("both_erase_cycles", 32'(n), 32'(DP));
        read_check("both_erased", 6'(DP - 1), 8'hFF);

        // Reset after two of five words
        prog_base = 6'd20; prog_len = 7'd5; prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        prog_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            word = 8'hA1 + 8'(i);
            prog_data = word;
            step();
        end
        prog_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        step();
        check("rstmid_done_late", 32'(done), 32'd0);
        read_check("rstmid_w0", 6'd20, 8'hA1);
        read_check("rstmid_w1", 6'd21, 8'hA2);
        read_check("rstmid_w2", 6'd22, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
